// File: rtl/ir_zone_alarm_controller.sv
// Multi-zone IR beam-break alarm controller: per-zone sync + debounce, masked trip, five-state arming FSM.
// Optional instant-alarm zones are enabled by defining IR_INSTANT_ZONE_EN.
module ir_zone_alarm_controller #(
   parameter int NUM_ZONES       = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EXIT_DELAY      = 1000,
   parameter int ENTRY_DELAY     = 1000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_ZONES-1:0] irSensor,
   input  logic [NUM_ZONES-1:0] zoneEnable,
   input  logic                 armReq,
   input  logic                 disarmReq,
`ifdef IR_INSTANT_ZONE_EN
   input  logic [NUM_ZONES-1:0] instantZone,
`endif
   output logic                 alarmActive,
   output logic                 systemArmed,
   output logic                 exitPending,
   output logic                 entryPending,
   output logic [2:0]           fsmState,
   output logic [NUM_ZONES-1:0] trippedZones,
   output logic [NUM_ZONES-1:0] zoneLevel
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int MAX_DL = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
   localparam int DL_W   = $clog2(MAX_DL + 1);

   typedef enum logic [2:0] {
      S_DISARMED = 3'd0,
      S_EXIT     = 3'd1,
      S_ARMED    = 3'd2,
      S_ENTRY    = 3'd3,
      S_ALARM    = 3'd4
   } state_t;

   state_t                 state;
   logic [DL_W-1:0]        delay_cnt;
   logic [NUM_ZONES-1:0]   sync1;
   logic [NUM_ZONES-1:0]   sync2;
   logic [DB_W-1:0]        deb_cnt [NUM_ZONES];
   logic [NUM_ZONES-1:0]   hits;
   logic                   trip;
   logic                   instant_hit;

   assign hits     = zoneLevel & zoneEnable;
   assign trip     = |hits;
   assign fsmState = state;

`ifdef IR_INSTANT_ZONE_EN
   assign instant_hit = |(hits & instantZone);
`else
   assign instant_hit = 1'b0;
`endif

   // Status flags {alarmActive, systemArmed, exitPending, entryPending} for a given state.
   function automatic logic [3:0] status_of(input state_t s);
      case (s)
         S_EXIT:  status_of = 4'b0010;
         S_ARMED: status_of = 4'b0100;
         S_ENTRY: status_of = 4'b0101;
         S_ALARM: status_of = 4'b1100;
         default: status_of = 4'b0000;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1     <= '0;
         sync2     <= '0;
         zoneLevel <= '0;
         for (int i = 0; i < NUM_ZONES; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= irSensor;
         sync2 <= sync1;
         for (int i = 0; i < NUM_ZONES; i++) begin
            if (sync2[i] == zoneLevel[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] + 1'b1 == DB_W'(DEBOUNCE_CYCLES)) begin
               deb_cnt[i]   <= '0;
               zoneLevel[i] <= ~zoneLevel[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_DISARMED;
         delay_cnt    <= '0;
         trippedZones <= '0;
         {alarmActive, systemArmed, exitPending, entryPending} <= 4'b0000;
      end else if (disarmReq) begin
         state        <= S_DISARMED;
         delay_cnt    <= '0;
         trippedZones <= '0;
         {alarmActive, systemArmed, exitPending, entryPending} <= status_of(S_DISARMED);
      end else begin
         if (state == S_ARMED || state == S_ENTRY || state == S_ALARM)
            trippedZones <= trippedZones | hits;
         case (state)
            S_DISARMED: begin
               if (armReq) begin
                  state     <= S_EXIT;
                  delay_cnt <= DL_W'(EXIT_DELAY);
                  {alarmActive, systemArmed, exitPending, entryPending} <= status_of(S_EXIT);
               end
            end
            S_EXIT: begin
               // Counter never sits at zero here; <= 1 only guards against a stall.
               if (delay_cnt <= DL_W'(1)) begin
                  state     <= S_ARMED;
                  delay_cnt <= '0;
                  {alarmActive, systemArmed, exitPending, entryPending} <= status_of(S_ARMED);
               end else begin
                  delay_cnt <= delay_cnt - 1'b1;
               end
            end
            S_ARMED: begin
               if (instant_hit) begin
                  state <= S_ALARM;
                  {alarmActive, systemArmed, exitPending, entryPending} <= status_of(S_ALARM);
               end else if (trip) begin
                  state     <= S_ENTRY;
                  delay_cnt <= DL_W'(ENTRY_DELAY);
                  {alarmActive, systemArmed, exitPending, entryPending} <= status_of(S_ENTRY);
               end
            end
            S_ENTRY: begin
               if (instant_hit || delay_cnt <= DL_W'(1)) begin
                  state     <= S_ALARM;
                  delay_cnt <= '0;
                  {alarmActive, systemArmed, exitPending, entryPending} <= status_of(S_ALARM);
               end else begin
                  delay_cnt <= delay_cnt - 1'b1;
               end
            end
            S_ALARM: begin
               state <= S_ALARM;
            end
            default: begin
               state     <= S_DISARMED;
               delay_cnt <= '0;
               {alarmActive, systemArmed, exitPending, entryPending} <= status_of(S_DISARMED);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ir_zone_alarm_controller.sv
// Directed bench for ir_zone_alarm_controller with NUM_ZONES=4, DEBOUNCE_CYCLES=4, EXIT_DELAY=8, ENTRY_DELAY=6.
module tb_ir_zone_alarm_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irSensor;
   logic [3:0] zoneEnable;
   logic       armReq;
   logic       disarmReq;
`ifdef IR_INSTANT_ZONE_EN
   logic [3:0] instantZone;
`endif
   logic       alarmActive;
   logic       systemArmed;
   logic       exitPending;
   logic       entryPending;
   logic [2:0] fsmState;
   logic [3:0] trippedZones;
   logic [3:0] zoneLevel;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ir_zone_alarm_controller #(
      .NUM_ZONES(4), .DEBOUNCE_CYCLES(4), .EXIT_DELAY(8), .ENTRY_DELAY(6)
   ) dut (
      .clk(clk),
      .reset(reset),
      .irSensor(irSensor),
      .zoneEnable(zoneEnable),
      .armReq(armReq),
      .disarmReq(disarmReq),
`ifdef IR_INSTANT_ZONE_EN
      .instantZone(instantZone),
`endif
      .alarmActive(alarmActive),
      .systemArmed(systemArmed),
      .exitPending(exitPending),
      .entryPending(entryPending),
      .fsmState(fsmState),
      .trippedZones(trippedZones),
      .zoneLevel(zoneLevel)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Status as {alarmActive, systemArmed, exitPending, entryPending}.
   function automatic logic [31:0] status();
      return 32'({alarmActive, systemArmed, exitPending, entryPending});
   endfunction

   initial begin
      reset = 1'b1; irSensor = 4'h0; zoneEnable = 4'hF; armReq = 1'b0; disarmReq = 1'b0;
`ifdef IR_INSTANT_ZONE_EN
      instantZone = 4'h0;
`endif
      tick(2);
      reset = 1'b0;
      chk("rst_state", 32'(fsmState), 0);
      chk("rst_status", status(), 0);
      chk("rst_tripped", 32'(trippedZones), 0);
      chk("rst_level", 32'(zoneLevel), 0);

      // Arming: EXIT for exactly 8 cycles
      armReq = 1'b1; tick(); armReq = 1'b0;
      chk("arm_exit_state", 32'(fsmState), 1);
      chk("arm_exit_status", status(), 32'b0010);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("exit_hold", 32'(exitPending), 1);
      end
      tick();
      chk("armed_state", 32'(fsmState), 2);
      chk("armed_status", status(), 32'b0100);

      // Three-cycle glitch is filtered
      irSensor = 4'b0010; tick(3); irSensor = 4'b0000;
      tick(6);
      chk("glitch_level", 32'(zoneLevel), 0);
      chk("glitch_state", 32'(fsmState), 2);

      // Held input: level rises after 6 edges, ENTRY on the next edge
      irSensor = 4'b0010;
      tick(5);
      chk("deb_level_early", 32'(zoneLevel), 0);
      tick();
      chk("deb_level", 32'(zoneLevel), 4'b0010);
      chk("deb_still_armed", 32'(fsmState), 2);
      tick();
      chk("entry_state", 32'(fsmState), 3);
      chk("entry_status", status(), 32'b0101);
      chk("entry_tripped", 32'(trippedZones), 4'b0010);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) irSensor = 4'b0000;
         tick();
         chk("entry_hold", 32'(entryPending), 1);
      end
      tick();
      chk("alarm_state", 32'(fsmState), 4);
      chk("alarm_status", status(), 32'b1100);
      chk("alarm_tripped", 32'(trippedZones), 4'b0010);

      // Alarm stays latched after sensors clear
      tick(10);
      chk("latch_level", 32'(zoneLevel), 0);
      chk("latch_alarm", 32'(alarmActive), 1);
      chk("latch_tripped", 32'(trippedZones), 4'b0010);
      disarmReq = 1'b1; tick(); disarmReq = 1'b0;
      chk("disarm_state", 32'(fsmState), 0);
      chk("disarm_status", status(), 0);
      chk("disarm_tripped", 32'(trippedZones), 0);

      // Masked zone 0 never trips
      zoneEnable = 4'b1110;
      armReq = 1'b1; tick(); armReq = 1'b0;
      tick(8);
      chk("mask_armed", 32'(fsmState), 2);
      irSensor = 4'b0001;
      tick(10);
      chk("mask_level", 32'(zoneLevel), 4'b0001);
      chk("mask_state", 32'(fsmState), 2);
      chk("mask_tripped", 32'(trippedZones), 0);
      irSensor = 4'b0000;
      tick(8);
      chk("mask_level_clr", 32'(zoneLevel), 0);
      zoneEnable = 4'hF;

      // disarmReq beats armReq during ENTRY
      irSensor = 4'b0100;
      tick(7);
      chk("prio_entry", 32'(fsmState), 3);
      chk("prio_tripped", 32'(trippedZones), 4'b0100);
      armReq = 1'b1; disarmReq = 1'b1; tick(); armReq = 1'b0; disarmReq = 1'b0;
      chk("prio_state", 32'(fsmState), 0);
      chk("prio_status", status(), 0);
      chk("prio_tripped_clr", 32'(trippedZones), 0);
      irSensor = 4'b0000;

      // Reset mid-EXIT wins over armReq and clears zone levels
      armReq = 1'b1; tick(); armReq = 1'b0;
      tick(3);
      chk("rexit_pending", 32'(exitPending), 1);
      chk("rexit_level_pre", 32'(zoneLevel), 4'b0100);
      reset = 1'b1; armReq = 1'b1; tick(); reset = 1'b0; armReq = 1'b0;
      chk("rexit_state", 32'(fsmState), 0);
      chk("rexit_status", status(), 0);
      chk("rexit_level", 32'(zoneLevel), 0);
      chk("rexit_tripped", 32'(trippedZones), 0);

`ifdef IR_INSTANT_ZONE_EN
      // Instant zone skips ENTRY
      instantZone = 4'b1000;
      armReq = 1'b1; tick(); armReq = 1'b0;
      tick(8);
      chk("inst_armed", 32'(fsmState), 2);
      irSensor = 4'b1000;
      tick(6);
      chk("inst_level", 32'(zoneLevel), 4'b1000);
      chk("inst_pre", 32'(fsmState), 2);
      tick();
      chk("inst_alarm", 32'(fsmState), 4);
      chk("inst_status", status(), 32'b1100);
      irSensor = 4'b0000;
      disarmReq = 1'b1; tick(); disarmReq = 1'b0;
      chk("inst_disarm", 32'(fsmState), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
